// File: rtl/decode_pkg.sv
// decode_pkg: RV32I/M encodings, control-field constants and the decoded control bundle.
package decode_pkg;
   localparam logic [6:0] OPCODE_R      = 7'h33;
   localparam logic [6:0] OPCODE_I      = 7'h13;
   localparam logic [6:0] OPCODE_LOAD   = 7'h03;
   localparam logic [6:0] OPCODE_STORE  = 7'h23;
   localparam logic [6:0] OPCODE_BRANCH = 7'h63;
   localparam logic [6:0] OPCODE_JAL    = 7'h6f;
   localparam logic [6:0] OPCODE_JALR   = 7'h67;
   localparam logic [6:0] OPCODE_LUI    = 7'h37;
   localparam logic [6:0] OPCODE_AUIPC  = 7'h17;

   localparam logic [6:0] F7_BASE = 7'h00;
   localparam logic [6:0] F7_ALT  = 7'h20;
   localparam logic [6:0] F7_MEXT = 7'h01;

   localparam logic [2:0] F3_ADD  = 3'd0;
   localparam logic [2:0] F3_SLL  = 3'd1;
   localparam logic [2:0] F3_SLT  = 3'd2;
   localparam logic [2:0] F3_SLTU = 3'd3;
   localparam logic [2:0] F3_XOR  = 3'd4;
   localparam logic [2:0] F3_SR   = 3'd5;
   localparam logic [2:0] F3_OR   = 3'd6;
   localparam logic [2:0] F3_AND  = 3'd7;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;

   localparam logic [2:0] FMT_R = 3'd0;
   localparam logic [2:0] FMT_I = 3'd1;
   localparam logic [2:0] FMT_S = 3'd2;
   localparam logic [2:0] FMT_B = 3'd3;
   localparam logic [2:0] FMT_U = 3'd4;
   localparam logic [2:0] FMT_J = 3'd5;

   localparam logic [2:0] MEM_B = 3'd0;
   localparam logic [2:0] MEM_H = 3'd1;
   localparam logic [2:0] MEM_W = 3'd2;

   localparam logic [2:0] CMP_EQ  = 3'd0;
   localparam logic [2:0] CMP_NE  = 3'd1;
   localparam logic [2:0] CMP_LT  = 3'd4;
   localparam logic [2:0] CMP_GE  = 3'd5;
   localparam logic [2:0] CMP_LTU = 3'd6;
   localparam logic [2:0] CMP_GEU = 3'd7;

   localparam logic       SRC1_RS1  = 1'b0;
   localparam logic       SRC1_PC   = 1'b1;
   localparam logic [1:0] SRC2_RS2  = 2'd0;
   localparam logic [1:0] SRC2_IMM  = 2'd1;
   localparam logic [1:0] SRC2_FOUR = 2'd2;
   localparam logic       RD_ALU    = 1'b0;
   localparam logic       RD_MEM    = 1'b1;

   typedef struct packed {
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic        reg_wr_en;
      logic        jump_en;
      logic        branch_en;
      logic        mem_wr_en;
      logic        mem_rd_en;
      logic        load_sign;
      logic        rd_source;
      logic        is_jalr;
      logic        is_lui;
      logic        alu_src1;
      logic [1:0]  alu_src2;
      logic [3:0]  alu_op;
      logic [2:0]  format;
      logic [2:0]  mem_size;
      logic [2:0]  cmp_op;
      logic        illegal;
      logic        mext;
      logic [2:0]  mdiv_op;
   } ctrl_bundle_t;

   // alt is funct7[5]; it only matters for ADD/SUB and SRL/SRA
   function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
      case (f3)
         F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
         F3_SLL:  return ALU_SLL;
         F3_SLT:  return ALU_SLT;
         F3_SLTU: return ALU_SLTU;
         F3_XOR:  return ALU_XOR;
         F3_SR:   return alt ? ALU_SRA : ALU_SRL;
         F3_OR:   return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction
endpackage

// File: rtl/rv32_decode_comb.sv
// rv32_decode_comb: combinational RV32I decoder into ctrl_bundle_t.
// DECODE_MEXT_EN adds RV32M decode (mext/mdiv_op); otherwise funct7=0x01 on OP is illegal.
module rv32_decode_comb
   import decode_pkg::*;
(
   input  logic [31:0]  instr_i,
   output ctrl_bundle_t ctrl_o
);
   logic [6:0] opc;
   logic [2:0] f3;
   logic [6:0] f7;
   logic       f7_ok;
   ctrl_bundle_t c;
   assign opc   = instr_i[6:0];
   assign f3    = instr_i[14:12];
   assign f7    = instr_i[31:25];
   assign f7_ok = (f7 == F7_BASE) || (f7 == F7_ALT);
   always_comb begin
      c = '0;
      c.rd  = instr_i[11:7];
      c.rs1 = instr_i[19:15];
      c.rs2 = instr_i[24:20];
      case (opc)
         OPCODE_R: begin
            c.format    = FMT_R;
            c.reg_wr_en = 1'b1;
            c.alu_op    = alu_from_f3(f3, f7[5]);
            c.illegal   = !f7_ok;
`ifdef DECODE_MEXT_EN
            if (f7 == F7_MEXT) begin
               c.alu_op  = ALU_ADD;
               c.illegal = 1'b0;
               c.mext    = 1'b1;
               c.mdiv_op = f3;
            end
`endif
         end
         OPCODE_I: begin
            c.format    = FMT_I;
            c.reg_wr_en = 1'b1;
            c.alu_src2  = SRC2_IMM;
            c.alu_op    = alu_from_f3(f3, f3 == F3_SR && f7[5]);
            c.illegal   = (f3 == F3_SLL || f3 == F3_SR) && !f7_ok;
         end
         OPCODE_LOAD: begin
            c.format    = FMT_I;
            c.reg_wr_en = 1'b1;
            c.mem_rd_en = 1'b1;
            c.rd_source = RD_MEM;
            c.alu_src2  = SRC2_IMM;
            c.mem_size  = {1'b0, f3[1:0]};
            c.load_sign = !f3[2];
            c.illegal   = f3 == 3'd3 || f3[2:1] == 2'b11;
         end
         OPCODE_STORE: begin
            c.format    = FMT_S;
            c.mem_wr_en = 1'b1;
            c.alu_src2  = SRC2_IMM;
            c.mem_size  = {1'b0, f3[1:0]};
            c.illegal   = f3 > 3'd2;
         end
         OPCODE_BRANCH: begin
            c.format    = FMT_B;
            c.branch_en = 1'b1;
            c.cmp_op    = f3;
            c.illegal   = f3[2:1] == 2'b01;
         end
         OPCODE_JAL: begin
            c.format    = FMT_J;
            c.reg_wr_en = 1'b1;
            c.jump_en   = 1'b1;
            c.alu_src1  = SRC1_PC;
            c.alu_src2  = SRC2_FOUR;
         end
         OPCODE_JALR: begin
            c.format    = FMT_I;
            c.reg_wr_en = 1'b1;
            c.jump_en   = 1'b1;
            c.is_jalr   = 1'b1;
            c.alu_src1  = SRC1_RS1;
            c.alu_src2  = SRC2_FOUR;
         end
         OPCODE_LUI: begin
            c.format    = FMT_U;
            c.reg_wr_en = 1'b1;
            c.is_lui    = 1'b1;
            c.alu_src2  = SRC2_IMM;
         end
         OPCODE_AUIPC: begin
            c.format    = FMT_U;
            c.reg_wr_en = 1'b1;
            c.alu_src1  = SRC1_PC;
            c.alu_src2  = SRC2_IMM;
         end
         default: c.illegal = 1'b1;
      endcase
      c.imm = c.format == FMT_I ? {{20{instr_i[31]}}, instr_i[31:20]} :
              c.format == FMT_S ? {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]} :
              c.format == FMT_B ? {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0} :
              c.format == FMT_U ? {instr_i[31:12], 12'h000} :
              c.format == FMT_J ? {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0} : '0;
      // illegal instructions still flow downstream but must not change state
      if (c.illegal) begin
         c.reg_wr_en = 1'b0;
         c.mem_wr_en = 1'b0;
         c.mem_rd_en = 1'b0;
         c.jump_en   = 1'b0;
         c.branch_en = 1'b0;
      end
   end
   assign ctrl_o = c;
endmodule

// File: rtl/decode_queue_stage.sv
// decode_queue_stage: instruction queue + RV32I decode + registered valid/ready output.
// Define DECODE_MEXT_EN to decode RV32M in the embedded decoder.
module decode_queue_stage
   import decode_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PC_W  = 32
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            flush_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [31:0]     in_instr_i,
   input  logic [PC_W-1:0] in_pc_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [PC_W-1:0] out_pc_o,
   output logic [4:0]      rd_o,
   output logic [4:0]      rs1_o,
   output logic [4:0]      rs2_o,
   output logic [31:0]     imm_o,
   output logic            reg_wr_en_o,
   output logic            jump_en_o,
   output logic            branch_en_o,
   output logic            mem_wr_en_o,
   output logic            mem_rd_en_o,
   output logic            load_sign_o,
   output logic            rd_source_o,
   output logic            is_jalr_o,
   output logic            is_lui_o,
   output logic            alu_src1_o,
   output logic [1:0]      alu_src2_o,
   output logic [3:0]      alu_op_o,
   output logic [2:0]      format_o,
   output logic [2:0]      mem_size_o,
   output logic [2:0]      cmp_op_o,
   output logic            illegal_o,
   output logic            mext_o,
   output logic [2:0]      mdiv_op_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [PW:0] FULL = DEPTH[PW:0];
   logic [31:0]     instr_q [DEPTH];
   logic [PC_W-1:0] pc_q    [DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [PW:0]     count;
   logic            push, load;
   ctrl_bundle_t    head_ctrl, out_ctrl;
   logic [PC_W-1:0] out_pc;
   logic            out_valid;
   rv32_decode_comb u_dec (.instr_i(instr_q[rd_ptr]), .ctrl_o(head_ctrl));
   // full blocks pushes even if the head pops this cycle
   assign in_ready_o = rst_n_i && count != FULL;
   assign push = in_valid_i && in_ready_o && !flush_i;
   assign load = (!out_valid || out_ready_i) && count != '0 && !flush_i;
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         out_valid <= 1'b0;
         out_ctrl  <= '0;
         out_pc    <= '0;
      end else if (flush_i) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         out_valid <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (load) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(load);
         if (!out_valid || out_ready_i) out_valid <= count != '0;
         if (load) begin
            out_ctrl <= head_ctrl;
            out_pc   <= pc_q[rd_ptr];
         end
      end
   end
   always_ff @(posedge clk_i) begin
      if (push) begin
         instr_q[wr_ptr] <= in_instr_i;
         pc_q[wr_ptr]    <= in_pc_i;
      end
   end
   assign out_valid_o = out_valid;
   assign out_pc_o    = out_pc;
   assign rd_o        = out_ctrl.rd;
   assign rs1_o       = out_ctrl.rs1;
   assign rs2_o       = out_ctrl.rs2;
   assign imm_o       = out_ctrl.imm;
   assign reg_wr_en_o = out_ctrl.reg_wr_en;
   assign jump_en_o   = out_ctrl.jump_en;
   assign branch_en_o = out_ctrl.branch_en;
   assign mem_wr_en_o = out_ctrl.mem_wr_en;
   assign mem_rd_en_o = out_ctrl.mem_rd_en;
   assign load_sign_o = out_ctrl.load_sign;
   assign rd_source_o = out_ctrl.rd_source;
   assign is_jalr_o   = out_ctrl.is_jalr;
   assign is_lui_o    = out_ctrl.is_lui;
   assign alu_src1_o  = out_ctrl.alu_src1;
   assign alu_src2_o  = out_ctrl.alu_src2;
   assign alu_op_o    = out_ctrl.alu_op;
   assign format_o    = out_ctrl.format;
   assign mem_size_o  = out_ctrl.mem_size;
   assign cmp_op_o    = out_ctrl.cmp_op;
   assign illegal_o   = out_ctrl.illegal;
   assign mext_o      = out_ctrl.mext;
   assign mdiv_op_o   = out_ctrl.mdiv_op;
endmodule

// File: tb/tb_decode_queue_stage.sv
// tb_decode_queue_stage: directed + random checks of decode_queue_stage against a queue/decoder model.
// Expectations follow DECODE_MEXT_EN when it is defined for the build.
module tb_decode_queue_stage;
   import decode_pkg::*;
   localparam int DEPTH = 4;
   localparam int PC_W  = 32;
`ifdef DECODE_MEXT_EN
   localparam bit MEXT = 1'b1;
`else
   localparam bit MEXT = 1'b0;
`endif
   typedef struct packed {
      logic [31:0]     instr;
      logic [PC_W-1:0] pc;
   } item_t;

   logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [31:0] in_instr = '0;
   logic [PC_W-1:0] in_pc = '0, out_pc;
   logic in_ready, out_valid;
   logic [4:0] rd, rs1, rs2;
   logic [31:0] imm;
   logic reg_wr_en, jump_en, branch_en, mem_wr_en, mem_rd_en, load_sign, rd_source, is_jalr, is_lui, alu_src1;
   logic [1:0] alu_src2;
   logic [3:0] alu_op;
   logic [2:0] format, mem_size, cmp_op, mdiv_op;
   logic illegal, mext;
   ctrl_bundle_t obs;
   int cmp_n = 0, err_n = 0;
   item_t mq[$];
   item_t m_out;
   bit m_ov = 1'b0;

   always #5 clk = ~clk;

   decode_queue_stage #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .in_instr_i(in_instr), .in_pc_i(in_pc),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_pc_o(out_pc),
      .rd_o(rd), .rs1_o(rs1), .rs2_o(rs2), .imm_o(imm),
      .reg_wr_en_o(reg_wr_en), .jump_en_o(jump_en), .branch_en_o(branch_en),
      .mem_wr_en_o(mem_wr_en), .mem_rd_en_o(mem_rd_en), .load_sign_o(load_sign),
      .rd_source_o(rd_source), .is_jalr_o(is_jalr), .is_lui_o(is_lui), .alu_src1_o(alu_src1),
      .alu_src2_o(alu_src2), .alu_op_o(alu_op), .format_o(format), .mem_size_o(mem_size),
      .cmp_op_o(cmp_op), .illegal_o(illegal), .mext_o(mext), .mdiv_op_o(mdiv_op)
   );

   always_comb begin
      obs = '0;
      obs.rd = rd; obs.rs1 = rs1; obs.rs2 = rs2; obs.imm = imm;
      obs.reg_wr_en = reg_wr_en; obs.jump_en = jump_en; obs.branch_en = branch_en;
      obs.mem_wr_en = mem_wr_en; obs.mem_rd_en = mem_rd_en; obs.load_sign = load_sign;
      obs.rd_source = rd_source; obs.is_jalr = is_jalr; obs.is_lui = is_lui;
      obs.alu_src1 = alu_src1; obs.alu_src2 = alu_src2; obs.alu_op = alu_op;
      obs.format = format; obs.mem_size = mem_size; obs.cmp_op = cmp_op;
      obs.illegal = illegal; obs.mext = mext; obs.mdiv_op = mdiv_op;
   end

   task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
      cmp_n++;
      assert (o === e) else begin
         err_n++;
         $error("FAIL %s: observed %h expected %h", tag, o, e);
      end
   endtask

   // Reference decoder built field by field from the ISA rules
   function automatic ctrl_bundle_t ref_decode(input logic [31:0] w);
      ctrl_bundle_t e = '0;
      logic [3:0] tab [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
      logic [6:0] op = w[6:0];
      logic [6:0] f7 = w[31:25];
      logic [2:0] f3 = w[14:12];
      bit r = op == 7'h33, i = op == 7'h13, ld = op == 7'h03, st = op == 7'h23, br = op == 7'h63;
      bit jal = op == 7'h6f, jalr = op == 7'h67, lui = op == 7'h37, aui = op == 7'h17;
      bit mul = MEXT && r && f7 == 7'h01;
      bit f7_bad = !(f7 == 7'h00 || f7 == 7'h20);
      bit bad = !(r || i || ld || st || br || jal || jalr || lui || aui)
                || (ld && (f3 == 3 || f3 == 6 || f3 == 7)) || (st && f3 >= 3) || (br && (f3 == 2 || f3 == 3))
                || (r && !mul && f7_bad) || (i && (f3 == 1 || f3 == 5) && f7_bad);
      e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
      e.format = (i || ld || jalr) ? FMT_I : st ? FMT_S : br ? FMT_B : (lui || aui) ? FMT_U : jal ? FMT_J : FMT_R;
      case (e.format)
         FMT_I: e.imm = 32'($signed(w[31:20]));
         FMT_S: e.imm = 32'($signed({w[31:25], w[11:7]}));
         FMT_B: e.imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
         FMT_U: e.imm = {w[31:12], 12'h000};
         FMT_J: e.imm = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
         default: e.imm = 32'h0;
      endcase
      if ((r && !mul) || i) begin
         e.alu_op = tab[f3];
         if (f3 == 5 && w[30]) e.alu_op = ALU_SRA;
         if (r && f3 == 0 && w[30]) e.alu_op = ALU_SUB;
      end
      e.reg_wr_en = !bad && (r || i || ld || jal || jalr || lui || aui);
      e.jump_en   = !bad && (jal || jalr);
      e.branch_en = !bad && br;
      e.mem_wr_en = !bad && st;
      e.mem_rd_en = !bad && ld;
      e.load_sign = ld && !f3[2];
      e.rd_source = ld;
      e.is_jalr   = jalr;
      e.is_lui    = lui;
      e.alu_src1  = jal || aui;
      e.alu_src2  = (jal || jalr) ? SRC2_FOUR : (i || ld || st || lui || aui) ? SRC2_IMM : SRC2_RS2;
      e.mem_size  = (ld || st) ? {1'b0, f3[1:0]} : 3'd0;
      e.cmp_op    = br ? f3 : 3'd0;
      e.illegal   = bad;
      e.mext      = mul;
      e.mdiv_op   = mul ? f3 : 3'd0;
      return e;
   endfunction

   // One clock: drive inputs, check handshake, advance the model, check outputs
   task automatic cycle(input logic v, input logic [31:0] ins, input logic [PC_W-1:0] pc,
                        input logic ordy, input logic fl);
      bit m_rdy, push, load;
      in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
      m_rdy = mq.size() != DEPTH;
      #1 chk("in_ready", in_ready, m_rdy);
      push = v && m_rdy && !fl;
      load = !fl && (!m_ov || ordy) && mq.size() != 0;
      @(posedge clk);
      #1;
      if (fl) begin
         mq.delete();
         m_ov = 1'b0;
      end else begin
         if (!m_ov || ordy) m_ov = load;
         if (load) m_out = mq.pop_front();
         if (push) mq.push_back('{instr: ins, pc: pc});
      end
      chk("out_valid", out_valid, m_ov);
      if (m_ov) begin
         chk("out_pc", out_pc, m_out.pc);
         chk("bundle", obs, ref_decode(m_out.instr));
      end
   endtask

   function automatic logic [31:0] rand_instr();
      logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17};
      logic [31:0] w = $urandom;
      int s = $urandom_range(0, 10);
      int k = $urandom_range(0, 3);
      if (s < 9) w[6:0] = ops[s];
      w[31:25] = k == 0 ? 7'h00 : k == 1 ? 7'h20 : k == 2 ? 7'h01 : w[31:25];
      return w;
   endfunction

   initial begin
      in_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_bundle", obs, '0);
      chk("rst_out_pc", out_pc, '0);
      rst_n = 1'b1;
      // ADD x3,x1,x2
      cycle(1, 32'h002081B3, 32'h100, 1, 0);
      chk("add_latency", out_valid, 1'b0);
      cycle(0, 0, 0, 1, 0);
      chk("add_valid", out_valid, 1'b1);
      chk("add_op", alu_op, ALU_ADD);
      chk("add_regs", {rd, rs1, rs2}, {5'd3, 5'd1, 5'd2});
      chk("add_we", reg_wr_en, 1'b1);
      cycle(1, 32'h402081B3, 32'h104, 1, 0);
      cycle(0, 0, 0, 1, 0);
      chk("sub_op", alu_op, ALU_SUB);
      cycle(1, 32'h0080A283, 32'h108, 1, 0);
      cycle(0, 0, 0, 1, 0);
      chk("lw_rd", {mem_rd_en, rd_source}, {1'b1, RD_MEM});
      chk("lw_size", mem_size, MEM_W);
      chk("lw_imm", imm, 32'd8);
      chk("lw_reg", rd, 5'd5);
      cycle(1, 32'hFFFFFFFF, 32'h10C, 1, 0);
      cycle(0, 0, 0, 1, 0);
      chk("ill_flag", illegal, 1'b1);
      chk("ill_en", {reg_wr_en, mem_wr_en, mem_rd_en, jump_en, branch_en}, 5'b0);
      cycle(1, 32'h00002063, 32'h110, 1, 0);
      cycle(0, 0, 0, 1, 0);
      chk("beq_f3_ill", {illegal, branch_en}, 2'b10);
      cycle(1, 32'h022081B3, 32'h114, 1, 0);
      cycle(0, 0, 0, 1, 0);
`ifdef DECODE_MEXT_EN
      chk("mul_m", {mext, mdiv_op, illegal, reg_wr_en, alu_op}, {1'b1, 3'd0, 1'b0, 1'b1, ALU_ADD});
`else
      chk("mul_ill", {illegal, mext, mdiv_op}, {1'b1, 1'b0, 3'd0});
`endif
      cycle(0, 0, 0, 1, 0);
      // backpressure: DEPTH queued plus one held in the output register
      for (int i = 0; i < 6; i++) begin
         if (i == 5) chk("bp_full", in_ready, 1'b0);
         cycle(1, 32'h00108093 + 32'(i << 20), 32'(4 * i), 0, 0);
      end
      for (int k = 0; k < 5; k++) begin
         chk("bp_order", {out_valid, out_pc}, {1'b1, 32'(4 * k)});
         cycle(0, 0, 0, 1, 0);
      end
      chk("bp_drained", out_valid, 1'b0);
      // flush with a concurrent push
      for (int i = 0; i < 3; i++) cycle(1, 32'h00000013, 32'h200 + 32'(4 * i), 0, 0);
      cycle(1, 32'h00500093, 32'h300, 0, 1);
      chk("flush_valid", out_valid, 1'b0);
      chk("flush_ready", in_ready, 1'b1);
      cycle(0, 0, 0, 1, 0);
      chk("flush_drop", out_valid, 1'b0);
      for (int n = 0; n < 600; n++) begin
         if (n == 300) begin
            in_valid = 1'b0;
            #2 rst_n = 1'b0;
            #1;
            chk("arst_valid", out_valid, 1'b0);
            chk("arst_ready", in_ready, 1'b0);
            mq.delete();
            m_ov = 1'b0;
            @(posedge clk);
            #1 rst_n = 1'b1;
         end
         cycle($urandom_range(0, 3) != 0, rand_instr(), PC_W'($urandom),
               $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
      $finish;
   end
endmodule
